// File: rtl/mem_access_stage.sv
// MA stage of the 5-stage pipeline. Owns the word-addressed data memory and
// executes LW/SW with WAIT_CYCLES extra cycles each. ALU results pass through
// with one-cycle latency. Stalls EX (in_ready low) while an access is pending.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   flush              squash accepted/in-flight instruction
//   in_valid/in_ready  EX handshake
//   in_op              00 ALU, 01 LW, 10 SW, 11 bubble
//   in_addr/in_sdata   memory word address / store data
//   in_alu_result, in_rd, in_wb_en   ALU pass-through fields
//   out_valid          one-cycle retire pulse to WB
//   out_wb_data, out_rd, out_wb_en   write-back fields (hold between pulses)
//
// Optional feature, macro MA_PERF_CNT_EN: adds perf_loads, perf_stores and
// perf_stall 16-bit wrapping counters.
module mem_access_stage #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned AW          = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [15:0] in_addr,
  input  logic [15:0] in_sdata,
  input  logic [15:0] in_alu_result,
  input  logic [2:0]  in_rd,
  input  logic        in_wb_en,
  output logic        out_valid,
  output logic [15:0] out_wb_data,
  output logic [2:0]  out_rd,
  output logic        out_wb_en
`ifdef MA_PERF_CNT_EN
  ,
  output logic [15:0] perf_loads,
  output logic [15:0] perf_stores,
  output logic [15:0] perf_stall
`endif
);

  localparam logic [1:0] OpAlu = 2'b00;
  localparam logic [1:0] OpLw  = 2'b01;
  localparam logic [1:0] OpSw  = 2'b10;

  localparam bit         NoWait  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CntInit = 4'(NoWait ? 0 : WAIT_CYCLES - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [1:0]      op_q;
  logic [AW-1:0]   addr_q;
  logic [15:0]     sdata_q;
  logic [2:0]      rd_q;

  logic [15:0]     mem [DEPTH];

  logic            accept;
  logic            exec_mem;
  logic            retire;
  logic            mem_we;
  logic [1:0]      e_op;
  logic [AW-1:0]   e_idx;
  logic [15:0]     e_sdata;
  logic [2:0]      e_rd;
  logic [15:0]     ret_data;
  logic            ret_wb_en;

  assign in_ready = (state_q == StIdle);
  assign accept   = in_valid && in_ready && !flush;

  // Upper address bits are deliberately ignored (address wraps modulo DEPTH).
  logic unused_addr;
  assign unused_addr = ^in_addr;

  always_comb begin
    e_op      = in_op;
    e_idx     = in_addr[AW-1:0];
    e_sdata   = in_sdata;
    e_rd      = in_rd;
    exec_mem  = 1'b0;
    retire    = 1'b0;
    ret_data  = 16'h0;
    ret_wb_en = 1'b0;
    if (state_q == StBusy) begin
      e_op     = op_q;
      e_idx    = addr_q;
      e_sdata  = sdata_q;
      e_rd     = rd_q;
      exec_mem = !flush && (cnt_q == 4'd0);
      retire   = exec_mem;
    end else begin
      // With no wait states the access completes on the accept edge itself.
      exec_mem = accept && NoWait && (in_op == OpLw || in_op == OpSw);
      retire   = exec_mem || (accept && in_op == OpAlu);
    end
    unique case (e_op)
      OpAlu: begin
        ret_data  = in_alu_result;
        ret_wb_en = in_wb_en;
      end
      OpLw: begin
        ret_data  = mem[e_idx];
        ret_wb_en = 1'b1;
      end
      default: begin
        ret_data  = 16'h0;
        ret_wb_en = 1'b0;
      end
    endcase
  end

  assign mem_we = resetn && exec_mem && (e_op == OpSw);

  // Memory contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[e_idx] <= e_sdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      op_q        <= OpAlu;
      addr_q      <= '0;
      sdata_q     <= 16'h0;
      rd_q        <= 3'd0;
      out_valid   <= 1'b0;
      out_wb_data <= 16'h0;
      out_rd      <= 3'd0;
      out_wb_en   <= 1'b0;
    end else begin
      out_valid <= retire;
      if (retire) begin
        out_wb_data <= ret_data;
        out_rd      <= e_rd;
        out_wb_en   <= ret_wb_en;
      end
      unique case (state_q)
        StIdle: begin
          if (accept && !NoWait && (in_op == OpLw || in_op == OpSw)) begin
            op_q    <= in_op;
            addr_q  <= in_addr[AW-1:0];
            sdata_q <= in_sdata;
            rd_q    <= in_rd;
            cnt_q   <= CntInit;
            state_q <= StBusy;
          end
        end
        default: begin
          if (flush || cnt_q == 4'd0) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
      endcase
    end
  end

`ifdef MA_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_loads  <= 16'h0;
      perf_stores <= 16'h0;
      perf_stall  <= 16'h0;
    end else begin
      if (retire && e_op == OpLw) perf_loads <= perf_loads + 16'd1;
      if (retire && e_op == OpSw) perf_stores <= perf_stores + 16'd1;
      if (state_q == StBusy) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench: u_dut1 has one wait state, u_dut0 has none. Both share the
// input bus; each phase checks only the instance it targets.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_op = 2'b11;
  logic [15:0] in_addr = 16'h0;
  logic [15:0] in_sdata = 16'h0;
  logic [15:0] in_alu_result = 16'h0;
  logic [2:0]  in_rd = 3'd0;
  logic        in_wb_en = 1'b0;

  logic        r1, v1, we1, r0, v0, we0;
  logic [15:0] d1, d0;
  logic [2:0]  rd1, rd0;
`ifdef MA_PERF_CNT_EN
  logic [15:0] pl1, ps1, pst1, pl0, ps0, pst0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DEPTH(256), .AW(8), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(r1),
    .in_op(in_op), .in_addr(in_addr), .in_sdata(in_sdata), .in_alu_result(in_alu_result),
    .in_rd(in_rd), .in_wb_en(in_wb_en), .out_valid(v1), .out_wb_data(d1), .out_rd(rd1),
    .out_wb_en(we1)
`ifdef MA_PERF_CNT_EN
    , .perf_loads(pl1), .perf_stores(ps1), .perf_stall(pst1)
`endif
  );

  mem_access_stage #(.DEPTH(256), .AW(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(r0),
    .in_op(in_op), .in_addr(in_addr), .in_sdata(in_sdata), .in_alu_result(in_alu_result),
    .in_rd(in_rd), .in_wb_en(in_wb_en), .out_valid(v0), .out_wb_data(d0), .out_rd(rd0),
    .out_wb_en(we0)
`ifdef MA_PERF_CNT_EN
    , .perf_loads(pl0), .perf_stores(ps0), .perf_stall(pst0)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] sdata,
                       input logic [15:0] alu, input logic [2:0] rd, input logic wb_en);
    in_valid      = 1'b1;
    in_op         = op;
    in_addr       = addr;
    in_sdata      = sdata;
    in_alu_result = alu;
    in_rd         = rd;
    in_wb_en      = wb_en;
  endtask

  task automatic idle_bus();
    in_valid = 1'b0;
    in_op    = 2'b11;
  endtask

  // Issue a memory op to u_dut1 and stop at its retire edge (two edges later).
  task automatic mem_op1(input logic [1:0] op, input logic [15:0] addr,
                         input logic [15:0] sdata, input logic [2:0] rd);
    drive(op, addr, sdata, 16'h0, rd, 1'b0);
    step();
    idle_bus();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) step();
    check_eq("rst_valid", 32'(v1), 32'd0);
    check_eq("rst_data", 32'(d1), 32'h0);
    check_eq("rst_rd", 32'(rd1), 32'd0);
    check_eq("rst_wb_en", 32'(we1), 32'd0);
    check_eq("rst_ready", 32'(r1), 32'd1);
    resetn = 1'b1;
    step();

    // ALU pass-through, latency 1.
    drive(2'b00, 16'h0, 16'h0, 16'h1234, 3'd3, 1'b1);
    step();
    idle_bus();
    check_eq("alu_valid", 32'(v1), 32'd1);
    check_eq("alu_data", 32'(d1), 32'h1234);
    check_eq("alu_rd", 32'(rd1), 32'd3);
    check_eq("alu_wb_en", 32'(we1), 32'd1);
    step();
    check_eq("alu_valid_drop", 32'(v1), 32'd0);
    check_eq("alu_data_hold", 32'(d1), 32'h1234);

    // SW then LW, one wait state.
    drive(2'b10, 16'h0005, 16'hBEEF, 16'h0, 3'd1, 1'b0);
    step();
    idle_bus();
    check_eq("sw_ready_low", 32'(r1), 32'd0);
    check_eq("sw_not_yet", 32'(v1), 32'd0);
    step();
    check_eq("sw_valid", 32'(v1), 32'd1);
    check_eq("sw_wb_en", 32'(we1), 32'd0);
    check_eq("sw_data", 32'(d1), 32'h0);
    check_eq("sw_ready_back", 32'(r1), 32'd1);
    drive(2'b01, 16'h0005, 16'h0, 16'h0, 3'd2, 1'b0);
    step();
    idle_bus();
    check_eq("lw_ready_low", 32'(r1), 32'd0);
    check_eq("lw_not_yet", 32'(v1), 32'd0);
    step();
    check_eq("lw_valid", 32'(v1), 32'd1);
    check_eq("lw_data", 32'(d1), 32'hBEEF);
    check_eq("lw_wb_en", 32'(we1), 32'd1);
    check_eq("lw_rd", 32'(rd1), 32'd2);

    // Address wrap: 0x0100 aliases index 0.
    mem_op1(2'b10, 16'h0100, 16'hA5A5, 3'd0);
    mem_op1(2'b01, 16'h0000, 16'h0, 3'd4);
    check_eq("wrap_valid", 32'(v1), 32'd1);
    check_eq("wrap_data", 32'(d1), 32'hA5A5);

    // Flushed store must not write or retire.
    mem_op1(2'b10, 16'h0007, 16'h1111, 3'd0);
    drive(2'b10, 16'h0007, 16'h2222, 16'h0, 3'd0, 1'b0);
    step();
    idle_bus();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_no_valid", 32'(v1), 32'd0);
    check_eq("flush_ready", 32'(r1), 32'd1);
    step();
    check_eq("flush_no_valid2", 32'(v1), 32'd0);
    mem_op1(2'b01, 16'h0007, 16'h0, 3'd6);
    check_eq("flush_lw_data", 32'(d1), 32'h1111);

    // Zero wait states: three ALU ops then LW, continuous retirement.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(2'b00, 16'h0, 16'h0, 16'(16'h0100 + i), 3'(i), 1'b1);
      else drive(2'b01, 16'h0005, 16'h0, 16'h0, 3'd5, 1'b0);
      check_eq("b2b_ready", 32'(r0), 32'd1);
      step();
      check_eq("b2b_valid", 32'(v0), 32'd1);
      if (i < 3) check_eq("b2b_alu_data", 32'(d0), 32'(16'h0100 + i));
      else check_eq("b2b_lw_data", 32'(d0), 32'hBEEF);
    end
    idle_bus();
    check_eq("b2b_ready_end", 32'(r0), 32'd1);
    step();
    check_eq("b2b_valid_drop", 32'(v0), 32'd0);
    step();

    // Reset while a store is pending.
    mem_op1(2'b10, 16'h0009, 16'h0001, 3'd5);
    check_eq("pre_rst_rd", 32'(rd1), 32'd5);
    drive(2'b10, 16'h0009, 16'h3333, 16'h0, 3'd7, 1'b0);
    step();
    idle_bus();
    check_eq("pre_rst_busy", 32'(r1), 32'd0);
    resetn = 1'b0;
    #1;
    check_eq("arst_ready", 32'(r1), 32'd1);
    check_eq("arst_rd", 32'(rd1), 32'd0);
    check_eq("arst_valid", 32'(v1), 32'd0);
`ifdef MA_PERF_CNT_EN
    check_eq("arst_perf_loads", 32'(pl1), 32'd0);
    check_eq("arst_perf_stores", 32'(ps1), 32'd0);
    check_eq("arst_perf_stall", 32'(pst1), 32'd0);
`endif
    step();
    check_eq("arst_held_valid", 32'(v1), 32'd0);
    resetn = 1'b1;
    step();
    mem_op1(2'b01, 16'h0009, 16'h0, 3'd1);
    check_eq("lost_store_valid", 32'(v1), 32'd1);
    check_eq("lost_store_data", 32'(d1), 32'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
